t01_tick_gen: RTL and testbench

T01_TICK_GEN -- requirements
Module: t01_tick_gen

---
 rtl/team_01_pkg.sv | 23 ++
 rtl/t01_tick_chan.sv | 115 +++++++++++
 rtl/t01_tick_gen.sv | 83 ++++++++
 tb/tb_t01_tick_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/team_01_pkg.sv
// ---------------------------------------------------------------------------
// team_01_pkg -- shared types and default constants for the team_01 blocks.
//
// Contents:
//   chan_state_t    : per-channel tick FSM state (IDLE / RUN / DONE)
//   T01_*           : default parameter values used by t01_tick_gen and
//                     t01_tick_chan
// ---------------------------------------------------------------------------
package team_01_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

    localparam int T01_NCH        = 4;
    localparam int T01_CNT_W      = 26;
    localparam int T01_DEF_PERIOD = 12500000;
    localparam int T01_MIN_PERIOD = 100;
    localparam int T01_FAST_SHIFT = 4;

endpackage

// File: rtl/t01_tick_chan.sv
// ---------------------------------------------------------------------------
// t01_tick_chan -- one independent tick channel: effective-period clamp,
// wrap counter and IDLE/RUN/DONE control FSM.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   period   in   programmed period for this channel (CNT_W)
//   en       in   channel enable (level); low forces IDLE
//   fast     in   fast mode: period is right-shifted by FAST_SHIFT
//   oneshot  in   stop in DONE after the next tick
//   restart  in   pulse: clear count (RUN) or re-arm (DONE)
//   pause    in   global freeze of count and state
//   tick     out  registered one-cycle tick
//   active   out  registered "channel is in RUN"
// ---------------------------------------------------------------------------
module t01_tick_chan
    import team_01_pkg::*;
#(
    parameter int CNT_W      = T01_CNT_W,
    parameter int MIN_PERIOD = T01_MIN_PERIOD,
    parameter int FAST_SHIFT = T01_FAST_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             en,
    input  logic             fast,
    input  logic             oneshot,
    input  logic             restart,
    input  logic             pause,
    output logic             tick,
    output logic             active
);

    chan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             tick_reg, tick_next;
    logic             active_reg;

    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] peff;
    logic [CNT_W-1:0] wrap_at;
    logic             at_wrap;

    // Peff is never below MIN_PERIOD (>= 2), so Peff-1 cannot underflow and
    // count+1 cannot overflow because count only increments below Peff-1.
    always_comb begin
        shifted = fast ? (period >> FAST_SHIFT) : period;
        peff    = (shifted < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : shifted;
        wrap_at = peff - CNT_W'(1);
        // ">=" rather than "==" so that a shrinking period wraps on the next
        // compare instead of counting all the way around.
        at_wrap = (count_reg >= wrap_at);
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tick_next  = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (!pause) begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_RUN;
                    count_next = '0;
                end
                ST_RUN: begin
                    // restart wins over a coincident wrap and eats its tick
                    if (restart) begin
                        count_next = '0;
                    end else if (at_wrap) begin
                        tick_next  = 1'b1;
                        count_next = '0;
                        if (oneshot) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    count_next = '0;
                    if (restart) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            tick_reg   <= tick_next;
            active_reg <= (state_next == ST_RUN);
        end
    end

    assign tick   = tick_reg;
    assign active = active_reg;

endmodule

// File: rtl/t01_tick_gen.sv
// ---------------------------------------------------------------------------
// t01_tick_gen -- NCH independent programmable tick generators.
//
// Holds one period register per channel (written through cfg_we/cfg_ch/
// cfg_period) and instantiates one t01_tick_chan per channel.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   cfg_we      in   period-register write strobe
//   cfg_ch      in   channel index for the write (out-of-range ignored)
//   cfg_period  in   period value to write (stored unclamped)
//   ch_en       in   per-channel enable, level
//   ch_fast     in   per-channel fast mode, level
//   ch_oneshot  in   per-channel one-shot mode, level
//   ch_restart  in   per-channel restart pulse
//   pause       in   global freeze of all counters
//   tick        out  per-channel registered one-cycle tick
//   ch_active   out  per-channel registered RUN indicator
// ---------------------------------------------------------------------------
module t01_tick_gen
    import team_01_pkg::*;
#(
    parameter int NCH        = T01_NCH,
    parameter int CNT_W      = T01_CNT_W,
    parameter int DEF_PERIOD = T01_DEF_PERIOD,
    parameter int MIN_PERIOD = T01_MIN_PERIOD,
    parameter int FAST_SHIFT = T01_FAST_SHIFT,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   ch_fast,
    input  logic [NCH-1:0]   ch_oneshot,
    input  logic [NCH-1:0]   ch_restart,
    input  logic             pause,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   ch_active
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNT_W-1:0] period_reg;
            logic             wr_hit;

            // An index >= NCH matches no channel, so such writes fall away.
            assign wr_hit = cfg_we && (int'(cfg_ch) == gi);

            // The new period is visible from the cycle after the write; the
            // write cycle's tick decision still sees the old value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    period_reg <= CNT_W'(DEF_PERIOD);
                end else if (wr_hit) begin
                    period_reg <= cfg_period;
                end
            end

            t01_tick_chan #(
                .CNT_W      (CNT_W),
                .MIN_PERIOD (MIN_PERIOD),
                .FAST_SHIFT (FAST_SHIFT)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .period  (period_reg),
                .en      (ch_en[gi]),
                .fast    (ch_fast[gi]),
                .oneshot (ch_oneshot[gi]),
                .restart (ch_restart[gi]),
                .pause   (pause),
                .tick    (tick[gi]),
                .active  (ch_active[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_t01_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_t01_tick_gen -- directed scenarios plus a randomized run, every cycle
// compared against a behavioural model of the tick channels.
// ---------------------------------------------------------------------------
module tb_t01_tick_gen;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int DEF_P = 30;
    localparam int MIN_P = 4;
    localparam int FS    = 4;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   ch_fast;
    logic [NCH-1:0]   ch_oneshot;
    logic [NCH-1:0]   ch_restart;
    logic             pause;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   ch_active;

    t01_tick_gen #(
        .NCH        (NCH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_P),
        .MIN_PERIOD (MIN_P),
        .FAST_SHIFT (FS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .ch_en      (ch_en),
        .ch_fast    (ch_fast),
        .ch_oneshot (ch_oneshot),
        .ch_restart (ch_restart),
        .pause      (pause),
        .tick       (tick),
        .ch_active  (ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: per channel, the programmed period, whether it is
    // running / finished, how many counting cycles have elapsed since the
    // last wrap, and whether a tick was produced at the latest edge.
    int m_period [NCH];
    bit m_run    [NCH];
    bit m_done   [NCH];
    int m_elapsed[NCH];
    bit m_tick   [NCH];

    int tq [NCH][$];   // edge numbers at which the DUT showed a tick

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @edge%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int peff(input int p, input bit f);
        int s;
        s = f ? (p >> FS) : p;
        return (s < MIN_P) ? MIN_P : s;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c]  = DEF_P;
            m_run[c]     = 1'b0;
            m_done[c]    = 1'b0;
            m_elapsed[c] = 0;
            m_tick[c]    = 1'b0;
        end
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    function automatic void model_edge();
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 1'b0;
            if (!ch_en[c]) begin
                m_run[c] = 1'b0; m_done[c] = 1'b0; m_elapsed[c] = 0;
            end else if (pause) begin
                // frozen
            end else if (m_done[c]) begin
                if (ch_restart[c]) begin
                    m_done[c] = 1'b0; m_run[c] = 1'b1; m_elapsed[c] = 0;
                end
            end else if (!m_run[c]) begin
                m_run[c] = 1'b1; m_elapsed[c] = 0;
            end else if (ch_restart[c]) begin
                m_elapsed[c] = 0;
            end else if (m_elapsed[c] + 1 >= peff(m_period[c], ch_fast[c])) begin
                m_tick[c] = 1'b1;
                m_elapsed[c] = 0;
                if (ch_oneshot[c]) begin
                    m_run[c] = 1'b0; m_done[c] = 1'b1;
                end
            end else begin
                m_elapsed[c] = m_elapsed[c] + 1;
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) m_period[cfg_ch] = int'(cfg_period);
    endfunction

    task automatic step();
        logic [NCH-1:0] et, ea;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            et[c] = m_tick[c];
            ea[c] = m_run[c];
        end
        check("tick", 32'(tick), 32'(et));
        check("ch_active", 32'(ch_active), 32'(ea));
        for (int c = 0; c < NCH; c++) if (tick[c]) tq[c].push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int ch, input int p);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = CNT_W'(p);
        $display("cfg write: ch=%0d period=%0d edge=%0d", ch, p, cyc + 1);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic clear_q();
        for (int c = 0; c < NCH; c++) tq[c].delete();
    endtask

    task automatic check_ticks(input string tag, input int ch, input int n, input int first, input int gap);
        check({tag, "_count"}, 32'(tq[ch].size()), 32'(n));
        for (int i = 0; i < n && i < tq[ch].size(); i++)
            check({tag, "_edge"}, 32'(tq[ch][i]), 32'(first + i * gap));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tick"}, 32'(tick), 32'd0);
        check({tag, "_active"}, 32'(ch_active), 32'd0);
    endtask

    int e0, r0, w0;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        ch_en = '0; ch_fast = '0; ch_oneshot = '0; ch_restart = '0; pause = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        $display("reset released");

        // Plain periodic ticking, period 10
        cfg(0, 10);
        clear_q();
        ch_en[0] = 1'b1; e0 = cyc + 1; step(); run(40);
        check_ticks("period10", 0, 4, e0 + 10, 10);
        $display("scenario period10 done, ticks=%0d", tq[0].size());

        // Fast mode: 160>>4 = 10
        ch_en[0] = 1'b0; ch_fast[0] = 1'b1; cfg(0, 160); clear_q();
        ch_en[0] = 1'b1; e0 = cyc + 1; step(); run(40);
        check_ticks("fast160", 0, 4, e0 + 10, 10);

        // Fast mode: 32>>4 = 2, clamped to MIN_P = 4
        ch_en[0] = 1'b0; cfg(0, 32); clear_q();
        ch_en[0] = 1'b1; e0 = cyc + 1; step(); run(20);
        check_ticks("fast_clamp", 0, 5, e0 + 4, 4);
        $display("scenario fast done");

        // One-shot then restart on ch1
        ch_en[0] = 1'b0; ch_fast[0] = 1'b0; cfg(1, 8); clear_q();
        ch_oneshot[1] = 1'b1; ch_en[1] = 1'b1; e0 = cyc + 1; step(); run(20);
        check_ticks("oneshot", 1, 1, e0 + 8, 0);
        check("oneshot_active", 32'(ch_active[1]), 32'd0);
        ch_restart[1] = 1'b1; r0 = cyc + 1; step(); ch_restart[1] = 1'b0; run(20);
        check("oneshot_restart_count", 32'(tq[1].size()), 32'd2);
        if (tq[1].size() == 2) check("oneshot_restart_edge", 32'(tq[1][1]), 32'(r0 + 8));
        $display("scenario oneshot done");

        // Pause for 5 cycles at count 12 on ch2
        ch_en[1] = 1'b0; ch_oneshot[1] = 1'b0; cfg(2, 20); clear_q();
        ch_en[2] = 1'b1; e0 = cyc + 1; step(); run(12);
        pause = 1'b1; run(5); pause = 1'b0; run(20);
        check_ticks("pause", 2, 1, e0 + 25, 0);
        $display("scenario pause done");

        // Shrink period at count 15, then restart coincident with a wrap
        ch_en[2] = 1'b0; cfg(3, 20); clear_q();
        ch_en[3] = 1'b1; e0 = cyc + 1; step(); run(15);
        w0 = cyc + 1; cfg(3, 10); run(20);
        run(10);
        ch_restart[3] = 1'b1; step(); ch_restart[3] = 1'b0; run(12);
        check("shrink_count", 32'(tq[3].size()), 32'd4);
        if (tq[3].size() == 4) begin
            check("shrink_first", 32'(tq[3][0]), 32'(w0 + 1));
            check("shrink_second", 32'(tq[3][1]), 32'(w0 + 11));
            check("shrink_third", 32'(tq[3][2]), 32'(w0 + 21));
            check("restart_beats_wrap", 32'(tq[3][3]), 32'(w0 + 41));
        end
        $display("scenario shrink/restart done");

        // Randomized traffic against the model
        ch_en = '1;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 31) == 0) ch_en[c] = ~ch_en[c];
                if ($urandom_range(0, 15) == 0) ch_fast[c] = ~ch_fast[c];
                if ($urandom_range(0, 15) == 0) ch_oneshot[c] = ~ch_oneshot[c];
                ch_restart[c] = ($urandom_range(0, 11) == 0);
            end
            pause = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) begin
                cfg($urandom_range(0, NCH - 1), $urandom_range(0, 40));
            end else begin
                step();
            end
        end
        ch_restart = '0; pause = 1'b0;
        $display("random phase done at edge %0d", cyc);

        // Asynchronous reset mid-count, then default period applies
        ch_en = '0; ch_fast = '0; ch_oneshot = '0; step();
        cfg(0, 10);
        ch_en[0] = 1'b1; step(); run(7);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk); @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0; clear_q();
        e0 = cyc + 1; step(); run(34);
        check_ticks("default_period", 0, 1, e0 + DEF_P, 0);
        $display("scenario async reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
